button_event_generator: RTL and testbench

//  Producer side of the clock's button-event interface. Synchronises and debounces

---
 rtl/clock_pkg.sv | 37 +++
 rtl/btn_debounce.sv | 156 +++++++++++++++
 rtl/button_event_generator.sv | 70 +++++++
 tb/tb_button_event_generator.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the clock's button-event interface.
//   N_BTN       : number of buttons, bit order {C,L,R,D,U} = [4:0]
//   TICK_HZ     : nominal scan-tick rate
//   CNT_W       : default width of per-button debounce/hold counters
//   BTN_*       : one-hot event codes presented on btn_event
//   prio_pick() : one-hot of the highest-priority set bit, C > U > D > L > R
package clock_pkg;

  localparam int unsigned N_BTN   = 5;
  localparam int unsigned TICK_HZ = 200;
  localparam int unsigned CNT_W   = 8;

  localparam logic [N_BTN-1:0] BTN_U = 5'b00001;
  localparam logic [N_BTN-1:0] BTN_D = 5'b00010;
  localparam logic [N_BTN-1:0] BTN_R = 5'b00100;
  localparam logic [N_BTN-1:0] BTN_L = 5'b01000;
  localparam logic [N_BTN-1:0] BTN_C = 5'b10000;

  typedef enum logic [1:0] {
    HOLD_IDLE   = 2'd0,
    HOLD_DELAY  = 2'd1,
    HOLD_REPEAT = 2'd2
  } hold_state_e;

  // Priority encoder for the event arbiter; result is one-hot or zero.
  function automatic logic [N_BTN-1:0] prio_pick(input logic [N_BTN-1:0] pend);
    logic [N_BTN-1:0] pick;
    pick = '0;
    if      (|(pend & BTN_C)) pick = BTN_C;
    else if (|(pend & BTN_U)) pick = BTN_U;
    else if (|(pend & BTN_D)) pick = BTN_D;
    else if (|(pend & BTN_L)) pick = BTN_L;
    else if (|(pend & BTN_R)) pick = BTN_R;
    return pick;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, tick-based debounce, optional auto-repeat
// hold FSM and a pending-event flag that the top-level arbiter consumes.
//   clk, reset : system clock, async active-high reset
//   tick_i     : one-clk scan strobe; all timing counts ticks
//   raw_i      : raw button pin, asynchronous to clk
//   grant_i    : arbiter consumed this button's pending event
//   level_o    : debounced level
//   pending_o  : an event is waiting for arbitration
module btn_debounce
  import clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 4,
  parameter int unsigned REPEAT_DELAY   = 100,
  parameter int unsigned REPEAT_PERIOD  = 20,
  parameter int unsigned CNT_W          = clock_pkg::CNT_W,
  parameter bit          REPEAT_EN      = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_i,
  input  logic raw_i,
  input  logic grant_i,
  output logic level_o,
  output logic pending_o
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic             sync1_q, sync2_q;
  logic             armed_q, armed_d;
  logic             stable_q, stable_d;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  hold_state_e      state_q, state_d;
  logic             press_c, repeat_c;

  // Metastability synchroniser.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed_q    <= 1'b0;
      stable_q   <= 1'b0;
      pending_q  <= 1'b0;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      state_q    <= HOLD_IDLE;
    end else begin
      armed_q    <= armed_d;
      stable_q   <= stable_d;
      pending_q  <= pending_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      state_q    <= state_d;
    end
  end

  // Debounce. After reset the button stays disarmed until it has read
  // released for DEBOUNCE_TICKS ticks, so a press held through reset never
  // produces an event.
  always_comb begin
    armed_d  = armed_q;
    stable_d = stable_q;
    db_cnt_d = db_cnt_q;
    press_c  = 1'b0;
    if (tick_i) begin
      if (!armed_q) begin
        if (sync2_q) begin
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          armed_d  = 1'b1;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = (&db_cnt_q) ? db_cnt_q : db_cnt_q + CNT_W'(1);
        end
      end else if (sync2_q != stable_q) begin
        if (db_cnt_q == DB_LAST) begin
          stable_d = sync2_q;
          db_cnt_d = '0;
          press_c  = sync2_q;
        end else begin
          db_cnt_d = (&db_cnt_q) ? db_cnt_q : db_cnt_q + CNT_W'(1);
        end
      end else begin
        db_cnt_d = '0;
      end
    end
  end

  // Auto-repeat hold FSM; a release from any state returns to idle.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    repeat_c   = 1'b0;
    case (state_q)
      HOLD_IDLE: begin
        hold_cnt_d = '0;
        if (press_c && REPEAT_EN) state_d = HOLD_DELAY;
      end
      HOLD_DELAY: begin
        if (!stable_q) begin
          state_d    = HOLD_IDLE;
          hold_cnt_d = '0;
        end else if (tick_i) begin
          if (hold_cnt_q == DLY_LAST) begin
            repeat_c   = 1'b1;
            state_d    = HOLD_REPEAT;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = (&hold_cnt_q) ? hold_cnt_q : hold_cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD_REPEAT: begin
        if (!stable_q) begin
          state_d    = HOLD_IDLE;
          hold_cnt_d = '0;
        end else if (tick_i) begin
          if (hold_cnt_q == PER_LAST) begin
            repeat_c   = 1'b1;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = (&hold_cnt_q) ? hold_cnt_q : hold_cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d    = HOLD_IDLE;
        hold_cnt_d = '0;
      end
    endcase
  end

  // Pending flag: a new set in the same cycle as a grant wins (re-queued).
  always_comb begin
    pending_d = pending_q;
    if (grant_i)              pending_d = 1'b0;
    if (press_c || repeat_c)  pending_d = 1'b1;
  end

  assign level_o   = stable_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/button_event_generator.sv
// Producer side of the button-event interface: per-button debounce/repeat
// channels plus a tick-timed priority arbiter (C > U > D > L > R) that
// presents at most one one-hot event per tick, held for a full tick period.
// The button count is fixed by clock_pkg::N_BTN.
//   clk       : system clock
//   reset     : async active-high reset
//   tick      : one-clk scan strobe
//   btn_raw   : raw button pins {C,L,R,D,U}
//   btn_event : one-hot event code or 0, updates only on tick cycles
//   btn_level : debounced button levels
module button_event_generator
  import clock_pkg::*;
#(
  parameter int unsigned      DEBOUNCE_TICKS = 4,
  parameter int unsigned      REPEAT_DELAY   = 100,
  parameter int unsigned      REPEAT_PERIOD  = 20,
  parameter logic [N_BTN-1:0] REPEAT_MASK    = BTN_U | BTN_D,
  parameter int unsigned      CNT_W          = clock_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_event,
  output logic [N_BTN-1:0] btn_level
);

  logic [N_BTN-1:0] pending_c;
  logic [N_BTN-1:0] pick_c;
  logic [N_BTN-1:0] grant_c;
  logic [N_BTN-1:0] btn_event_q, btn_event_d;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .CNT_W          (CNT_W),
      .REPEAT_EN      (REPEAT_MASK[i])
    ) u_db (
      .clk       (clk),
      .reset     (reset),
      .tick_i    (tick),
      .raw_i     (btn_raw[i]),
      .grant_i   (grant_c[i]),
      .level_o   (btn_level[i]),
      .pending_o (pending_c[i])
    );
  end

  // Arbiter: grant and event update happen only on tick, so the event
  // stays constant for a whole tick period.
  always_comb begin
    pick_c      = prio_pick(pending_c);
    grant_c     = '0;
    btn_event_d = btn_event_q;
    if (tick) begin
      grant_c     = pick_c;
      btn_event_d = pick_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) btn_event_q <= '0;
    else       btn_event_q <= btn_event_d;
  end

  assign btn_event = btn_event_q;

endmodule

// File: tb/tb_button_event_generator.sv
// Scoreboard bench for button_event_generator: stimulus pushes the expected
// event code and tick number; a monitor compares on every tick.
module tb_button_event_generator;

  logic       clk;
  logic       reset;
  logic       tick;
  logic [4:0] btn_raw;
  logic [4:0] btn_event;
  logic [4:0] btn_level;

  typedef struct {
    logic [4:0] code;
    int         t;
  } exp_t;

  exp_t exp_q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   tick_no = 0;

  button_event_generator dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .btn_raw   (btn_raw),
    .btn_event (btn_event),
    .btn_level (btn_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One tick every four clocks.
  initial begin
    tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (tick %0d)", name, act, req, tick_no);
    end
  endtask

  task automatic expect_ev(input logic [4:0] code, input int t);
    exp_t e;
    e.code = code;
    e.t    = t;
    exp_q.push_back(e);
  endtask

  // Leaves the caller 2 time units after the n-th following tick edge.
  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (!tick);
    end
    #2;
  endtask

  // Monitor: counts ticks and checks events against the scoreboard.
  initial begin
    logic [4:0] prev_ev;
    exp_t       e;
    prev_ev = '0;
    forever begin
      @(posedge clk);
      #1;
      if (tick) tick_no++;
      check("onehot0", 32'($onehot0(btn_event)), 32'd1);
      if (!reset && !tick) check("hold_between_ticks", 32'(btn_event), 32'(prev_ev));
      if (tick && !reset) begin
        if (exp_q.size() > 0 && exp_q[0].t == tick_no) begin
          e = exp_q.pop_front();
          check("event_code", 32'(btn_event), 32'(e.code));
        end else if (btn_event != 5'd0) begin
          check("unexpected_event", 32'(btn_event), 32'd0);
        end
      end
      prev_ev = btn_event;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout actual=%0d required=finish", tick_no);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset   = 1'b1;
    btn_raw = '0;
    repeat (3) @(negedge clk);
    check("reset_event", 32'(btn_event), 32'd0);
    check("reset_level", 32'(btn_level), 32'd0);
    reset = 1'b0;
    wait_ticks(8);

    // Clean U press: event 5 ticks after the stimulus tick, level follows.
    k = tick_no;
    btn_raw[0] = 1'b1;
    expect_ev(5'd1, k + 5);
    wait_ticks(5);
    check("u_level_high", 32'(btn_level), 32'd1);
    wait_ticks(5);
    btn_raw[0] = 1'b0;
    wait_ticks(8);
    check("u_level_low", 32'(btn_level), 32'd0);

    // R high for 3 ticks only: rejected by debounce.
    btn_raw[2] = 1'b1;
    wait_ticks(3);
    btn_raw[2] = 1'b0;
    wait_ticks(8);
    check("r_glitch_level", 32'(btn_level), 32'd0);

    // R high for exactly 4 ticks: accepted.
    k = tick_no;
    btn_raw[2] = 1'b1;
    expect_ev(5'd4, k + 5);
    wait_ticks(4);
    btn_raw[2] = 1'b0;
    wait_ticks(8);

    // D bounces, then settles high: single event timed from the last edge.
    btn_raw[1] = 1'b1;
    wait_ticks(1);
    btn_raw[1] = 1'b0;
    wait_ticks(1);
    btn_raw[1] = 1'b1;
    k = tick_no;
    expect_ev(5'd2, k + 5);
    wait_ticks(10);
    btn_raw[1] = 1'b0;
    wait_ticks(8);

    // U held: press event, then repeats 100 and 120,140,160,180 ticks later.
    k = tick_no;
    btn_raw[0] = 1'b1;
    expect_ev(5'd1, k + 5);
    expect_ev(5'd1, k + 105);
    expect_ev(5'd1, k + 125);
    expect_ev(5'd1, k + 145);
    expect_ev(5'd1, k + 165);
    expect_ev(5'd1, k + 185);
    wait_ticks(196);
    btn_raw[0] = 1'b0;
    wait_ticks(8);

    // C and L together: C first, L on the next tick.
    k = tick_no;
    btn_raw[4] = 1'b1;
    btn_raw[3] = 1'b1;
    expect_ev(5'd16, k + 5);
    expect_ev(5'd8,  k + 6);
    wait_ticks(5);
    check("cl_level", 32'(btn_level), 32'd24);
    wait_ticks(5);
    btn_raw[4] = 1'b0;
    btn_raw[3] = 1'b0;
    wait_ticks(8);

    // L held 300 ticks: no auto-repeat.
    k = tick_no;
    btn_raw[3] = 1'b1;
    expect_ev(5'd8, k + 5);
    wait_ticks(300);
    btn_raw[3] = 1'b0;
    wait_ticks(8);

    // Reset while U is held and its event is being presented.
    k = tick_no;
    btn_raw[0] = 1'b1;
    expect_ev(5'd1, k + 5);
    wait_ticks(5);
    check("pre_reset_level", 32'(btn_level), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_reset_event", 32'(btn_event), 32'd0);
    check("mid_reset_level", 32'(btn_level), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_ticks(120);
    btn_raw[0] = 1'b0;
    wait_ticks(6);
    k = tick_no;
    btn_raw[0] = 1'b1;
    expect_ev(5'd1, k + 5);
    wait_ticks(10);
    btn_raw[0] = 1'b0;
    wait_ticks(8);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
